mux_n_stream: RTL and testbench

- Parametrised N-to-1 channel selector: successor to the fixed 8-way, 32-bit combinational mux.
- Adds a registered output stage with a valid/ready handshake on every channel.
- Has two selection modes:
  - fixed: an external select input picks the channel.
  - round-robin: a rotating grant pointer picks among valid channels.
- Sits between multiple producers (register-file read ports, bypass sources, memory return paths) and a single pipelined consumer.

---
 rtl/mux_n_stream_pkg.sv | 12 +
 rtl/mux_n_stream_rr_pick.sv | 25 ++
 rtl/mux_n_stream.sv | 83 ++++++++
 tb/tb_mux_n_stream.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_n_stream_pkg.sv
// Shared definitions for the N-to-1 stream selector and related arbiters.
package mux_n_stream_pkg;

  localparam logic MUX_MODE_FIXED = 1'b0;
  localparam logic MUX_MODE_RR    = 1'b1;

  // Channel-index width; never narrower than one bit.
  function automatic int unsigned chan_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_stream_rr_pick.sv
// Rotating-priority picker: first requester after ptr, scanning upward with wrap.
module mux_n_stream_rr_pick
  import mux_n_stream_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned SELW = chan_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned off = 1; off <= N; off++) begin
      if (!gnt_any && req[SELW'((32'(ptr) + off) % N)]) begin
        gnt_any = 1'b1;
        gnt_idx = SELW'((32'(ptr) + off) % N);
      end
    end
  end

endmodule

// File: rtl/mux_n_stream.sv
// N-to-1 channel selector with registered output, valid/ready on every channel,
// and fixed or round-robin selection.
module mux_n_stream
  import mux_n_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 8,
  parameter int unsigned SELW  = chan_w(N)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    select,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] chan_data [N];
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  rr_idx;
  logic             rr_any;
  logic [SELW-1:0]  pick_idx;
  logic [N-1:0]     ready_vec;
  logic             load;
  logic             sel_in_range;
  logic             accept;

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign chan_data[k] = in_data[k*WIDTH +: WIDTH];
  end

  mux_n_stream_rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  assign load         = !out_valid || out_ready;
  assign sel_in_range = 32'(select) < N;

  // Ready is a one-hot of the chosen channel; in fixed mode it ignores in_valid.
  always_comb begin
    ready_vec = '0;
    pick_idx  = select;
    if (mode == MUX_MODE_RR) begin
      pick_idx = rr_idx;
      if (rr_any && load) ready_vec = N'(1) << rr_idx;
    end else begin
      if (sel_in_range && load) ready_vec = N'(1) << select;
    end
    if (!reset_n) ready_vec = '0;
  end

  assign in_ready = ready_vec;
  assign accept   = |(ready_vec & in_valid);

  // Output register and pointer; pointer only advances on a round-robin accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SELW'(N - 1);
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= chan_data[pick_idx];
      out_chan  <= pick_idx;
      if (mode == MUX_MODE_RR) ptr <= pick_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_stream.sv
// Self-checking bench for mux_n_stream: directed scenarios plus randomized traffic
// against a behavioural model of the selection rules.
module tb_mux_n_stream;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [255:0]  in_data;
  logic [7:0]    in_valid;
  logic [7:0]    in_ready;
  logic          mode;
  logic [2:0]    select;
  logic [31:0]   out_data;
  logic [2:0]    out_chan;
  logic          out_valid;
  logic          out_ready;

  logic [191:0]  in_data6;
  logic [5:0]    in_valid6;
  logic [5:0]    in_ready6;
  logic          mode6;
  logic [2:0]    select6;
  logic [31:0]   out_data6;
  logic [2:0]    out_chan6;
  logic          out_valid6;
  logic          out_ready6;

  int checks = 0;
  int failures = 0;

  int          m_ptr;
  bit          m_valid;
  logic [31:0] m_data;
  int          m_chan;

  always #5 clock = ~clock;

  mux_n_stream #(.WIDTH(32), .N(8)) dut (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .select(select), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_n_stream #(.WIDTH(32), .N(6)) dut6 (
    .clock(clock), .reset_n(reset_n), .in_data(in_data6), .in_valid(in_valid6),
    .in_ready(in_ready6), .mode(mode6), .select(select6), .out_data(out_data6),
    .out_chan(out_chan6), .out_valid(out_valid6), .out_ready(out_ready6)
  );

  // Which channel the rules allow this cycle (-1 = none), ignoring in_valid in fixed mode.
  function automatic int model_offer();
    bit ld;
    ld = !m_valid || out_ready;
    if (!ld) return -1;
    if (mode == 1'b0) return int'(select);
    for (int off = 1; off <= 8; off++) begin
      if (in_valid[(m_ptr + off) % 8]) return (m_ptr + off) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_ready();
    int k;
    logic [7:0] r;
    k = model_offer();
    r = 8'h00;
    if (k >= 0) r[k] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = 7; m_valid = 0; m_data = 32'h0; m_chan = 0;
  endtask

  // Apply the clock edge to the model, then advance the DUT to just after the edge.
  task automatic tick();
    int k;
    k = model_offer();
    if (k >= 0 && in_valid[k]) begin
      m_valid = 1; m_data = in_data[k*32 +: 32]; m_chan = k;
      if (mode == 1'b1) m_ptr = k;
    end else if (out_ready) begin
      m_valid = 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic randomize_data();
    for (int k = 0; k < 8; k++) in_data[k*32 +: 32] = $urandom;
    for (int k = 0; k < 6; k++) in_data6[k*32 +: 32] = $urandom;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 8'hFF; mode = 1'b0; select = 3'd0; out_ready = 1'b1;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_chan !== 3'd0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b d=%h c=%0d expected v=0 d=0 c=0", out_valid, out_data, out_chan);
    end
    checks++;
    if (in_ready !== 8'h00) begin
      failures++;
      $display("FAIL reset_in_ready: got %h expected 00", in_ready);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    in_valid = 8'h00;
    #1;
  endtask

  task automatic test_fixed();
    randomize_data();
    mode = 1'b0; select = 3'd5; in_valid = 8'h20; out_ready = 1'b1;
    in_data[5*32 +: 32] = 32'hDEADBEEF;
    #1;
    checks++;
    if (in_ready !== 8'h20) begin
      failures++;
      $display("FAIL fixed_ready: got %h expected 20", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_chan !== 3'd5) begin
      failures++;
      $display("FAIL fixed_output: got v=%b d=%h c=%0d expected v=1 d=deadbeef c=5", out_valid, out_data, out_chan);
    end
    in_valid = 8'h00;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL fixed_drain: got v=%b d=%h expected v=0 d=deadbeef", out_valid, out_data);
    end
  endtask

  task automatic test_rr_full();
    apply_reset();
    randomize_data();
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (in_ready !== (8'h01 << (i % 8))) begin
        failures++;
        $display("FAIL rr_full_ready[%0d]: got %h expected %h", i, in_ready, 8'h01 << (i % 8));
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_chan !== 3'(i % 8) || out_data !== in_data[(i % 8)*32 +: 32]) begin
        failures++;
        $display("FAIL rr_full_out[%0d]: got v=%b c=%0d d=%h expected v=1 c=%0d d=%h",
                 i, out_valid, out_chan, out_data, i % 8, in_data[(i % 8)*32 +: 32]);
      end
    end
  endtask

  task automatic test_rr_sparse();
    logic [7:0] exp_r [3];
    int         exp_c [3];
    exp_r[0] = 8'h80; exp_r[1] = 8'h04; exp_r[2] = 8'h80;
    exp_c[0] = 7;     exp_c[1] = 2;     exp_c[2] = 7;
    apply_reset();
    randomize_data();
    mode = 1'b1; in_valid = 8'h04; out_ready = 1'b1;
    tick();
    in_valid = 8'b1000_0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== exp_r[i]) begin
        failures++;
        $display("FAIL rr_sparse_ready[%0d]: got %h expected %h", i, in_ready, exp_r[i]);
      end
      tick();
      checks++;
      if (out_chan !== 3'(exp_c[i]) || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL rr_sparse_chan[%0d]: got c=%0d v=%b expected c=%0d v=1", i, out_chan, out_valid, exp_c[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] v4;
    apply_reset();
    randomize_data();
    v4 = $urandom;
    mode = 1'b1; in_valid = 8'h08; out_ready = 1'b1;
    in_data[3*32 +: 32] = 32'h1234;
    #1;
    tick();
    checks++;
    if (out_data !== 32'h1234 || out_chan !== 3'd3 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_first: got d=%h c=%0d v=%b expected d=00001234 c=3 v=1", out_data, out_chan, out_valid);
    end
    out_ready = 1'b0; in_valid = 8'h10; in_data[4*32 +: 32] = v4;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (in_ready !== 8'h00) begin
        failures++;
        $display("FAIL bp_stall_ready[%0d]: got %h expected 00", i, in_ready);
      end
      tick();
      checks++;
      if (out_data !== 32'h1234 || out_chan !== 3'd3 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_stall_hold[%0d]: got d=%h c=%0d v=%b expected d=00001234 c=3 v=1", i, out_data, out_chan, out_valid);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 8'h10) begin
      failures++;
      $display("FAIL bp_release_ready: got %h expected 10", in_ready);
    end
    tick();
    checks++;
    if (out_data !== v4 || out_chan !== 3'd4 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_out: got d=%h c=%0d v=%b expected d=%h c=4 v=1", out_data, out_chan, out_valid, v4);
    end
  endtask

  task automatic test_out_of_range();
    logic [2:0] sels [2];
    sels[0] = 3'd7; sels[1] = 3'd6;
    randomize_data();
    in_valid = 8'h00;
    mode6 = 1'b0; in_valid6 = 6'h3F; out_ready6 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      select6 = sels[i % 2];
      #1;
      checks++;
      if (in_ready6 !== 6'h00) begin
        failures++;
        $display("FAIL oor_ready[%0d]: got %h expected 00", i, in_ready6);
      end
      tick();
      checks++;
      if (out_valid6 !== 1'b0) begin
        failures++;
        $display("FAIL oor_valid[%0d]: got %b expected 0", i, out_valid6);
      end
    end
    select6 = 3'd5;
    #1;
    checks++;
    if (in_ready6 !== 6'h20) begin
      failures++;
      $display("FAIL n6_top_ready: got %h expected 20", in_ready6);
    end
    tick();
    checks++;
    if (out_valid6 !== 1'b1 || out_chan6 !== 3'd5 || out_data6 !== in_data6[5*32 +: 32]) begin
      failures++;
      $display("FAIL n6_top_out: got v=%b c=%0d d=%h expected v=1 c=5 d=%h", out_valid6, out_chan6, out_data6, in_data6[5*32 +: 32]);
    end
    in_valid6 = 6'h00;
    tick();
  endtask

  task automatic test_reset_mid();
    randomize_data();
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_chan !== 3'd0 || in_ready !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset: got v=%b d=%h c=%0d r=%h expected v=0 d=0 c=0 r=00", out_valid, out_data, out_chan, in_ready);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 8'h01) begin
      failures++;
      $display("FAIL mid_reset_grant: got %h expected 01", in_ready);
    end
    tick();
    checks++;
    if (out_chan !== 3'd0 || out_valid !== 1'b1 || out_data !== in_data[31:0]) begin
      failures++;
      $display("FAIL mid_reset_first: got c=%0d v=%b d=%h expected c=0 v=1 d=%h", out_chan, out_valid, out_data, in_data[31:0]);
    end
  endtask

  task automatic test_random();
    logic [7:0] er;
    for (int i = 0; i < 400; i++) begin
      randomize_data();
      mode      = 1'($urandom_range(0, 1));
      select    = 3'($urandom_range(0, 7));
      in_valid  = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      er = model_ready();
      checks++;
      if (in_ready !== er) begin
        failures++;
        $display("FAIL rand_ready[%0d]: got %h expected %h", i, in_ready, er);
      end
      tick();
      checks++;
      if (out_valid !== m_valid || out_data !== m_data || out_chan !== 3'(m_chan)) begin
        failures++;
        $display("FAIL rand_out[%0d]: got v=%b d=%h c=%0d expected v=%b d=%h c=%0d",
                 i, out_valid, out_data, out_chan, m_valid, m_data, m_chan);
      end
    end
  endtask

  initial begin
    in_data = '0; in_valid = '0; mode = 1'b0; select = '0; out_ready = 1'b0;
    in_data6 = '0; in_valid6 = '0; mode6 = 1'b0; select6 = '0; out_ready6 = 1'b1;
    reset_n = 1'b1;
    #2;
    test_reset();
    test_fixed();
    test_rr_full();
    test_rr_sparse();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
